// File: rtl/load_store_unit.sv
// Load/store sequencer between a single-request upstream port and a byte-addressed
// memory with a shared bidirectional data bus; rejects misaligned/illegal sizes.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 20
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [1:0]            REQ_SIZE,
  input  logic                  REQ_SIGNED,
  input  logic [31:0]           REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [31:0]           RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  CS,
  output logic                  WE,
  output logic [ADDR_WIDTH-1:0] DATA_ADDR,
  output logic [1:0]            DATA_SIZE,
  output logic                  SIGNED,
  inout  wire  [31:0]           DATA_BUS
);

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_STORE = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_LWAIT = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]            r_state;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_cs;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_data_addr;
  logic [1:0]            r_data_size;
  logic                  r_data_signed;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [DATA_W-1:0]     r_wdata;

  logic [2:0]            w_state_nx;
  logic                  w_accept;
  logic                  w_misalign;
  logic                  w_mem_act;
  logic [ADDR_WIDTH-1:0] w_addr_nx;
  logic [1:0]            w_size_nx;
  logic                  w_signed_nx;
  logic [DATA_W-1:0]     w_wdata_nx;
  logic [DATA_W-1:0]     w_rdata_nx;
  logic                  w_err_nx;

  assign w_misalign = (REQ_SIZE == 2'b11)
                   || ((REQ_SIZE == 2'b01) && REQ_ADDR[0])
                   || ((REQ_SIZE == 2'b10) && (REQ_ADDR[1:0] != 2'b00));

  // Next state plus the registered values of every output for the coming cycle.
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (REQ_VALID) begin
          w_accept = 1'b1;
          if (w_misalign)  w_state_nx = S_RESP;
          else if (REQ_WE) w_state_nx = S_STORE;
          else             w_state_nx = S_LOAD;
        end
      end
      S_STORE: w_state_nx = S_RESP;
      S_LOAD:  w_state_nx = S_LWAIT;
      S_LWAIT: w_state_nx = S_RESP;
      S_RESP:  if (RSP_READY) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase

    w_addr_nx   = w_accept ? REQ_ADDR   : r_addr;
    w_size_nx   = w_accept ? REQ_SIZE   : r_size;
    w_signed_nx = w_accept ? REQ_SIGNED : r_signed;
    w_wdata_nx  = w_accept ? REQ_WDATA  : r_wdata;

    w_mem_act = (w_state_nx == S_STORE) || (w_state_nx == S_LOAD) || (w_state_nx == S_LWAIT);

    // Stores and errors answer with zero data; loads take the bus as the memory presents it.
    w_rdata_nx = r_rsp_rdata;
    w_err_nx   = r_rsp_err;
    if (w_accept) begin
      w_rdata_nx = '0;
      w_err_nx   = w_misalign;
    end else if (r_state == S_LWAIT) begin
      w_rdata_nx = DATA_BUS;
    end else if ((r_state == S_RESP) && RSP_READY) begin
      w_rdata_nx = '0;
      w_err_nx   = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_cs          <= 1'b0;
      r_we          <= 1'b0;
      r_data_addr   <= '0;
      r_data_size   <= 2'b00;
      r_data_signed <= 1'b0;
      r_addr        <= '0;
      r_size        <= 2'b00;
      r_signed      <= 1'b0;
      r_wdata       <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_req_ready   <= (w_state_nx == S_IDLE);
      r_rsp_valid   <= (w_state_nx == S_RESP);
      r_rsp_rdata   <= w_rdata_nx;
      r_rsp_err     <= w_err_nx;
      r_cs          <= w_mem_act;
      r_we          <= (w_state_nx == S_STORE);
      r_data_addr   <= w_mem_act ? w_addr_nx : '0;
      r_data_size   <= w_mem_act ? w_size_nx : 2'b00;
      r_data_signed <= w_mem_act ? w_signed_nx : 1'b0;
      r_addr        <= w_addr_nx;
      r_size        <= w_size_nx;
      r_signed      <= w_signed_nx;
      r_wdata       <= w_wdata_nx;
    end
  end

  assign REQ_READY = r_req_ready;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_RDATA = r_rsp_rdata;
  assign RSP_ERR   = r_rsp_err;
  assign CS        = r_cs;
  assign WE        = r_we;
  assign DATA_ADDR = r_data_addr;
  assign DATA_SIZE = r_data_size;
  assign SIGNED    = r_data_signed;

  // Bus is only ever driven during the single store cycle.
  assign DATA_BUS = (r_cs && r_we) ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte memory on the shared bus, a transaction-level
// reference model checked every cycle, and directed requests with literal results.
module tb_load_store_unit;

  localparam int unsigned AW = 20;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic          REQ_WE = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [1:0]    REQ_SIZE = 2'b00;
  logic          REQ_SIGNED = 1'b0;
  logic [31:0]   REQ_WDATA = '0;
  logic          RSP_VALID;
  logic          RSP_READY = 1'b1;
  logic [31:0]   RSP_RDATA;
  logic          RSP_ERR;
  logic          CS;
  logic          WE;
  logic [AW-1:0] DATA_ADDR;
  logic [1:0]    DATA_SIZE;
  logic          SIGNED;
  tri0  [31:0]   DATA_BUS;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .CS(CS), .WE(WE), .DATA_ADDR(DATA_ADDR), .DATA_SIZE(DATA_SIZE), .SIGNED(SIGNED),
    .DATA_BUS(DATA_BUS)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %08h, expected %08h", name, $time, got, exp);
    end
  endtask

  // Memory environment: little-endian bytes, extends reads per SIGNED/DATA_SIZE.
  logic [7:0]  mem [0:1023];
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] mem_rd;

  always_comb begin
    b0 = mem[DATA_ADDR[9:0]];
    b1 = mem[DATA_ADDR[9:0] + 10'd1];
    b2 = mem[DATA_ADDR[9:0] + 10'd2];
    b3 = mem[DATA_ADDR[9:0] + 10'd3];
    case (DATA_SIZE)
      2'b00:   mem_rd = SIGNED ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   mem_rd = SIGNED ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
      default: mem_rd = {b3, b2, b1, b0};
    endcase
  end

  assign DATA_BUS = (CS && !WE) ? mem_rd : 32'bz;

  always @(posedge CLK) begin
    if (CS && WE) begin
      mem[DATA_ADDR[9:0]] <= DATA_BUS[7:0];
      if (DATA_SIZE != 2'b00) mem[DATA_ADDR[9:0] + 10'd1] <= DATA_BUS[15:8];
      if (DATA_SIZE == 2'b10) begin
        mem[DATA_ADDR[9:0] + 10'd2] <= DATA_BUS[23:16];
        mem[DATA_ADDR[9:0] + 10'd3] <= DATA_BUS[31:24];
      end
    end
  end

  // Reference model: one outstanding transaction, timed in cycles since acceptance.
  logic [7:0]  ref_mem [0:1023];
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  int          m_lat  = 0;
  bit          m_err, m_we, m_sgn;
  int          m_addr, m_size;
  logic [31:0] m_wdata, m_rdata;

  function automatic logic [31:0] model_load(input int addr, input int size, input bit sgn);
    longint v = 0;
    int nbytes = 1 << size;
    for (int i = 0; i < nbytes; i++) v += longint'(ref_mem[(addr + i) % 1024]) << (8 * i);
    if (sgn && v >= (longint'(1) << (8 * nbytes - 1))) v -= longint'(1) << (8 * nbytes);
    return 32'(v);
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_busy <= 1'b0;
      m_age  <= 0;
    end else if (!m_busy) begin
      if (REQ_VALID) begin
        bit e;
        e = (REQ_SIZE == 2'd3) || (REQ_SIZE == 2'd1 && REQ_ADDR % 2 != 0)
            || (REQ_SIZE == 2'd2 && REQ_ADDR % 4 != 0);
        m_busy  <= 1'b1;
        m_age   <= 1;
        m_err   <= e;
        m_we    <= REQ_WE;
        m_sgn   <= REQ_SIGNED;
        m_addr  <= int'(REQ_ADDR);
        m_size  <= int'(REQ_SIZE);
        m_wdata <= REQ_WDATA;
        m_lat   <= e ? 1 : (REQ_WE ? 2 : 3);
        m_rdata <= (e || REQ_WE) ? 32'h0 : model_load(int'(REQ_ADDR), int'(REQ_SIZE), REQ_SIGNED);
      end
    end else if (m_age >= m_lat) begin
      if (RSP_READY) m_busy <= 1'b0;
    end else begin
      if (m_we && !m_err)
        for (int i = 0; i < (1 << m_size); i++) ref_mem[(m_addr + i) % 1024] <= m_wdata[8*i +: 8];
      m_age <= m_age + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      if (!m_busy) begin
        chk("idle_req_ready", 32'(REQ_READY), 32'd1);
        chk("idle_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("idle_cs", 32'(CS), 32'd0);
        chk("idle_data_addr", 32'(DATA_ADDR), 32'd0);
        chk("idle_bus_released", DATA_BUS, 32'h0);
      end else if (m_age < m_lat) begin
        chk("mem_req_ready", 32'(REQ_READY), 32'd0);
        chk("mem_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("mem_cs", 32'(CS), 32'd1);
        chk("mem_we", 32'(WE), 32'(m_we));
        chk("mem_data_addr", 32'(DATA_ADDR), 32'(m_addr));
        chk("mem_data_size", 32'(DATA_SIZE), 32'(m_size));
        chk("mem_signed", 32'(SIGNED), 32'(m_sgn));
        if (m_we) chk("store_bus", DATA_BUS, m_wdata);
      end else begin
        chk("resp_valid", 32'(RSP_VALID), 32'd1);
        chk("resp_req_ready", 32'(REQ_READY), 32'd0);
        chk("resp_cs", 32'(CS), 32'd0);
        chk("resp_we", 32'(WE), 32'd0);
        chk("resp_data_addr", 32'(DATA_ADDR), 32'd0);
        chk("resp_bus_released", DATA_BUS, 32'h0);
        chk("resp_err", 32'(RSP_ERR), 32'(m_err));
        chk("resp_rdata", RSP_RDATA, m_rdata);
      end
    end
  end

  // One request with literal expected error/data/latency; hold = cycles RSP_READY stays low in RESP.
  task automatic run_req(input logic we, input logic [AW-1:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata, input logic exp_err,
                         input logic [31:0] exp_rdata, input int exp_lat, input int hold);
    int cyc;
    logic [31:0] first;
    @(posedge CLK); #1;
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_SIZE = size;
    REQ_SIGNED = sgn; REQ_WDATA = wdata; RSP_READY = (hold == 0);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    cyc = 1;
    while (!RSP_VALID && cyc < 16) begin
      @(posedge CLK); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("lit_err", 32'(RSP_ERR), 32'(exp_err));
    chk("lit_rdata", RSP_RDATA, exp_rdata);
    first = RSP_RDATA;
    for (int k = 0; k < hold; k++) begin
      @(posedge CLK); #1;
      chk("hold_valid", 32'(RSP_VALID), 32'd1);
      chk("hold_rdata", RSP_RDATA, first);
      chk("hold_req_ready", 32'(REQ_READY), 32'd0);
    end
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    chk("after_handshake_valid", 32'(RSP_VALID), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req_ready", 32'(REQ_READY), 32'd1);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_rdata", RSP_RDATA, 32'h0);
    chk("rst_rsp_err", 32'(RSP_ERR), 32'd0);
    chk("rst_cs", 32'(CS), 32'd0);
    chk("rst_we", 32'(WE), 32'd0);
    chk("rst_data_addr", 32'(DATA_ADDR), 32'd0);
    chk("rst_data_size", 32'(DATA_SIZE), 32'd0);
    chk("rst_signed", 32'(SIGNED), 32'd0);
    chk("rst_bus", DATA_BUS, 32'h0);
    RST = 1'b0;
    chk_en = 1'b1;

    //      we    addr       size   sgn   wdata         err   rdata         lat hold
    run_req(1'b1, 20'h00013, 2'b00, 1'b0, 32'hFFFFFFAA, 1'b0, 32'h00000000, 2, 0);
    run_req(1'b0, 20'h00013, 2'b00, 1'b0, 32'h0,        1'b0, 32'h000000AA, 3, 0);
    run_req(1'b1, 20'h00034, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000, 2, 0);
    run_req(1'b0, 20'h00034, 2'b10, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 3, 0);
    run_req(1'b0, 20'h00036, 2'b00, 1'b0, 32'h0,        1'b0, 32'h000000AD, 3, 0);
    run_req(1'b0, 20'h00037, 2'b00, 1'b1, 32'h0,        1'b0, 32'hFFFFFFDE, 3, 0);
    run_req(1'b1, 20'h00041, 2'b00, 1'b0, 32'h00000080, 1'b0, 32'h00000000, 2, 0);
    run_req(1'b0, 20'h00041, 2'b00, 1'b1, 32'h0,        1'b0, 32'hFFFFFF80, 3, 0);
    run_req(1'b1, 20'h00070, 2'b01, 1'b0, 32'h00008123, 1'b0, 32'h00000000, 2, 0);
    run_req(1'b0, 20'h00070, 2'b01, 1'b1, 32'h0,        1'b0, 32'hFFFF8123, 3, 0);
    run_req(1'b0, 20'h00070, 2'b01, 1'b0, 32'h0,        1'b0, 32'h00008123, 3, 0);
    run_req(1'b0, 20'h00023, 2'b01, 1'b0, 32'h0,        1'b1, 32'h00000000, 1, 0);
    run_req(1'b1, 20'h00036, 2'b10, 1'b0, 32'h12345678, 1'b1, 32'h00000000, 1, 0);
    run_req(1'b0, 20'h00040, 2'b11, 1'b0, 32'h0,        1'b1, 32'h00000000, 1, 0);
    run_req(1'b0, 20'h00034, 2'b10, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 3, 4);
    run_req(1'b1, 20'h00050, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 32'h00000000, 2, 0);

    // Reset in the middle of a store cycle: no write, no response.
    @(posedge CLK); #1;
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 20'h00050; REQ_SIZE = 2'b10;
    REQ_SIGNED = 1'b0; REQ_WDATA = 32'h11223344;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    chk("mid_store_cs", 32'(CS), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("rst_drop_cs", 32'(CS), 32'd0);
    chk("rst_drop_we", 32'(WE), 32'd0);
    chk("rst_drop_bus", DATA_BUS, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rst_no_rsp", 32'(RSP_VALID), 32'd0);
    run_req(1'b0, 20'h00050, 2'b10, 1'b0, 32'h0,        1'b0, 32'hCAFEF00D, 3, 0);

    repeat (2) @(posedge CLK);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_WIDTH, default 20, memory byte-address width; matches memory DATA_ADDR.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 REQ_VALID  in  1  upstream access request valid.
REQ-005 REQ_READY  out  1  block can accept a request.
REQ-006 REQ_WE  in  1  1 = store, 0 = load.
REQ-007 REQ_ADDR  in  ADDR_WIDTH  byte address.
REQ-008 REQ_SIZE  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 REQ_SIGNED  in  1  sign-extend load result.
REQ-010 REQ_WDATA  in  32  store data, low-order bytes used per size.
REQ-011 RSP_VALID  out  1  response valid.
REQ-012 RSP_READY  in  1  upstream accepts response.
REQ-013 RSP_RDATA  out  32  load result (zero for stores and errors).
REQ-014 RSP_ERR  out  1  misaligned or illegal-size request.
REQ-015 CS  out  1  memory chip select.
REQ-016 WE  out  1  memory write enable.
REQ-017 DATA_ADDR  out  ADDR_WIDTH  memory data address.
REQ-018 DATA_SIZE  out  2  memory access size.
REQ-019 SIGNED  out  1  memory sign-extend control.
REQ-020 DATA_BUS  inout  32  shared bidirectional memory data bus.

Function
REQ-021 FSM states: IDLE, STORE, LOAD, LWAIT, RESP; REQ_READY = 1 only in IDLE.
REQ-022 Acceptance: REQ_VALID && REQ_READY at a rising edge; REQ_WE, REQ_ADDR, REQ_SIZE, REQ_SIGNED, REQ_WDATA are registered at that edge and held internally.
REQ-023 Alignment check at acceptance: error if REQ_SIZE==11, halfword with ADDR[0]!=0, or word with ADDR[1:0]!=00.
REQ-024 Error request: IDLE -> RESP directly; CS never asserted; RSP_ERR=1, RSP_RDATA=0.
REQ-025 Legal store: IDLE -> STORE for exactly one cycle with CS=1, WE=1; memory commits on the edge ending STORE; then -> RESP.
REQ-026 Legal load: IDLE -> LOAD -> LWAIT, CS=1, WE=0 in both cycles; DATA_BUS captured into RSP_RDATA on the edge ending LWAIT; then -> RESP.
REQ-027 DATA_ADDR, DATA_SIZE, SIGNED carry the registered request values whenever CS=1; 0 otherwise.
REQ-028 DATA_BUS driven with registered write data only in STORE (CS && WE); high-impedance in all other states and during reset.
REQ-029 Load result is taken as delivered by memory (memory performs extension per SIGNED); no re-extension in this block.
REQ-030 RESP: RSP_VALID=1 with RSP_RDATA and RSP_ERR stable until RSP_VALID && RSP_READY; then -> IDLE.
REQ-031 Latency from acceptance edge N: error RSP_VALID in cycle N+1; store N+2; load N+3 (RSP_READY held high).
REQ-032 New request is not accepted in the cycle the response handshakes; earliest next acceptance is the following edge (IDLE).
REQ-033 Address MSB wrap-around not applied; addresses beyond memory are passed through unchanged.

Reset
REQ-034 RST assertion immediately forces IDLE; CS=0, WE=0, DATA_ADDR=0, DATA_SIZE=0, SIGNED=0, DATA_BUS=Z, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, REQ_READY=1 after release.
REQ-035 Reset during STORE before its ending edge: no memory write occurs; in-flight request dropped with no response.
REQ-036 Reset during LOAD/LWAIT/RESP: pending response discarded.

Verification
REQ-037 Store byte 0xAA @0x13, then load unsigned byte @0x13 -> RSP_RDATA=0x000000AA, RSP_ERR=0, load RSP_VALID 3 cycles after acceptance.
REQ-038 Store word 0xDEADBEEF @0x34, load word @0x34 -> 0xDEADBEEF; DATA_BUS=Z in all cycles except the single STORE cycle.
REQ-039 Store byte 0x80 @0x41, load signed byte -> 0xFFFFFF80; store halfword 0x8123 @0x70, signed load -> 0xFFFF8123.
REQ-040 Halfword request @0x23, word @0x36, size 11 @0x40 -> each RSP_ERR=1, RSP_RDATA=0, RSP_VALID 1 cycle after acceptance, CS never 1.
REQ-041 RSP_READY held low 4 cycles during a load response -> RSP_VALID, RSP_RDATA stable, REQ_READY=0 until handshake.
REQ-042 RST pulsed mid-STORE of 0x11223344 @0x50 -> CS drops immediately, subsequent word load @0x50 returns the prior contents.
